// File: rtl/trace_feeder_pkg.sv
// rtl/trace_feeder_pkg.sv - shared state encoding and defaults for the trace feeder
package trace_feeder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CAPTURE,
    ST_PRESENT,
    ST_DONE
  } state_t;

  localparam logic [15:0] END_MARKER_DEF = 16'hFFFF;
  localparam int          CNT_W_DEF      = 16;

endpackage

// File: rtl/trace_feeder_if.sv
// rtl/trace_feeder_if.sv - presentation/completion handshake between feeder and cache lookup
interface trace_feeder_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] mem_trace;
  logic              trace_valid;
  logic              trace_strobe;
  logic              access_done;
  logic              access_hit;

  modport master (
    output mem_trace,
    output trace_valid,
    output trace_strobe,
    input  access_done,
    input  access_hit
  );

  modport slave (
    input  mem_trace,
    input  trace_valid,
    input  trace_strobe,
    output access_done,
    output access_hit
  );
endinterface

// File: rtl/trace_feeder_sat_counter.sv
// rtl/trace_feeder_sat_counter.sv - saturating up-counter used for the trace statistics
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);
  logic [W-1:0] r_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;
endmodule

// File: rtl/trace_feeder.sv
// rtl/trace_feeder.sv - handshaked trace ROM sequencer feeding the cache lookup stage
module trace_feeder
  import trace_feeder_pkg::*;
#(
  parameter int                ADDR_W      = 16,
  parameter int                PTR_W       = 10,
  parameter int                TRACE_DEPTH = 1024,
  parameter logic [ADDR_W-1:0] END_MARKER  = END_MARKER_DEF,
  parameter int                CNT_W       = CNT_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  output logic [PTR_W-1:0]  rom_addr,
  input  logic [ADDR_W-1:0] rom_data,
  trace_feeder_if.master    cache,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count,
  output logic [CNT_W-1:0]  access_count,
  output logic              finished
);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(TRACE_DEPTH - 1);

  state_t            r_state;
  logic [PTR_W-1:0]  r_ptr;
  logic [ADDR_W-1:0] r_mem_trace;
  logic              r_valid;
  logic              r_strobe;
  logic              r_finished;

  logic w_complete;
  logic w_hit_inc;
  logic w_miss_inc;

  // Completion pulses only count while an address is actually on offer.
  assign w_complete = (r_state == ST_PRESENT) && cache.access_done;
  assign w_hit_inc  = w_complete && cache.access_hit;
  assign w_miss_inc = w_complete && !cache.access_hit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_mem_trace <= '0;
      r_valid     <= 1'b0;
      r_strobe    <= 1'b0;
      r_finished  <= 1'b0;
    end else begin
      r_strobe <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (enable) r_state <= ST_FETCH;
        end
        ST_FETCH: begin
          r_state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (rom_data == END_MARKER) begin
            r_state <= ST_DONE;
          end else begin
            r_mem_trace <= rom_data;
            r_valid     <= 1'b1;
            r_strobe    <= 1'b1;
            r_state     <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (cache.access_done) begin
            r_valid <= 1'b0;
            // The last ROM slot is terminal; the pointer never wraps back to 0.
            if (r_ptr == LAST_PTR) begin
              r_state <= ST_DONE;
            end else begin
              r_ptr   <= r_ptr + 1'b1;
              r_state <= enable ? ST_FETCH : ST_IDLE;
            end
          end
        end
        ST_DONE: begin
          r_finished <= 1'b1;
          r_valid    <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_hit_cnt (
    .clock   (clock),
    .reset   (reset),
    .i_inc   (w_hit_inc),
    .o_count (hit_count)
  );

  sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clock   (clock),
    .reset   (reset),
    .i_inc   (w_miss_inc),
    .o_count (miss_count)
  );

  sat_counter #(.W(CNT_W)) u_access_cnt (
    .clock   (clock),
    .reset   (reset),
    .i_inc   (w_complete),
    .o_count (access_count)
  );

  assign rom_addr           = r_ptr;
  assign cache.mem_trace    = r_mem_trace;
  assign cache.trace_valid  = r_valid;
  assign cache.trace_strobe = r_strobe;
  assign finished           = r_finished;
endmodule

// File: tb/tb_trace_feeder.sv
// tb/tb_trace_feeder.sv - randomized self-checking bench for trace_feeder
module tb_trace_feeder;
  localparam int          PTR_W = 5;
  localparam int          DEPTH = 20;
  localparam int          CNT_W = 4;
  localparam int          CMAX  = (1 << CNT_W) - 1;
  localparam logic [15:0] END_M = 16'hFFFF;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b0;
  logic [PTR_W-1:0]  rom_addr;
  logic [15:0]       rom_data;
  logic [CNT_W-1:0]  hit_count;
  logic [CNT_W-1:0]  miss_count;
  logic [CNT_W-1:0]  access_count;
  logic              finished;
  logic [15:0]       rom [32];

  int n_vec = 0;
  int n_err = 0;

  trace_feeder_if #(.ADDR_W(16)) tif ();

  trace_feeder #(
    .ADDR_W      (16),
    .PTR_W       (PTR_W),
    .TRACE_DEPTH (DEPTH),
    .END_MARKER  (END_M),
    .CNT_W       (CNT_W)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .cache        (tif),
    .hit_count    (hit_count),
    .miss_count   (miss_count),
    .access_count (access_count),
    .finished     (finished)
  );

  always #5 clock = ~clock;

  always @(posedge clock) rom_data <= rom[rom_addr];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  // n non-marker entries followed by END_M; n >= 32 leaves no marker at all
  task automatic fill_rom(input int n);
    for (int i = 0; i < 32; i++)
      rom[i] = (i < n) ? 16'($urandom_range(0, 16'hFFFE)) : END_M;
  endtask

  // lat: 0 = random 1..4 cycles strobe-to-done; hit_mode: 0 random, 1 always hit
  task automatic run_trace(input int lat, input int hit_mode, input bit spurious,
                           input int drop_at, input int abort_at, input int idle_pre,
                           output int first_valid, output int first_fin);
    logic [15:0] exp_q[$];
    logic [15:0] held;
    int n_exp, exp_last, hits, misses, pres, cyc, done_at, abort_cyc, off_cnt, max_addr;
    bit waiting, drop_active;

    exp_q.delete();
    exp_last = DEPTH - 1;
    for (int i = 0; i < DEPTH; i++) begin
      if (rom[i] == END_M) begin
        exp_last = i;
        break;
      end
      exp_q.push_back(rom[i]);
    end
    n_exp = exp_q.size();

    tif.access_done = 1'b0;
    tif.access_hit  = 1'b0;
    enable = 1'b0;
    reset  = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_val("rst_valid", {31'd0, tif.trace_valid}, 0);
    check_val("rst_finished", {31'd0, finished}, 0);
    check_val("rst_access", 32'(access_count), 0);
    check_val("rst_rom_addr", 32'(rom_addr), 0);
    reset  = 1'b0;
    enable = (idle_pre == 0);

    cyc = 0; first_valid = -1; first_fin = -1; waiting = 0; drop_active = 0;
    done_at = -1; abort_cyc = -1; off_cnt = 0; max_addr = 0; pres = 0; hits = 0; misses = 0;
    held = '0;
    while (cyc < 1500 && !finished) begin
      @(posedge clock);
      @(negedge clock);
      cyc++;
      tif.access_done = 1'b0;
      if (abort_cyc >= 0 && cyc == abort_cyc + 1) begin
        reset = 1'b1;
        #1;
        check_val("abort_valid", {31'd0, tif.trace_valid}, 0);
        check_val("abort_strobe", {31'd0, tif.trace_strobe}, 0);
        check_val("abort_mem_trace", 32'(tif.mem_trace), 0);
        check_val("abort_counts", {20'd0, hit_count, miss_count, access_count}, 0);
        check_val("abort_finished", {31'd0, finished}, 0);
        check_val("abort_rom_addr", 32'(rom_addr), 0);
        return;
      end
      if (idle_pre > 0 && cyc == idle_pre) enable = 1'b1;
      if (int'(rom_addr) > max_addr) max_addr = int'(rom_addr);
      if (tif.trace_valid && first_valid < 0) first_valid = cyc;
      if (finished && first_fin < 0) first_fin = cyc;
      if (waiting) begin
        check_val("valid_hold", {31'd0, tif.trace_valid}, 1);
        check_val("mem_hold", 32'(tif.mem_trace), 32'(held));
      end
      if (drop_active && !waiting) begin
        check_val("parked_valid", {31'd0, tif.trace_valid}, 0);
        off_cnt++;
        if (off_cnt == 6) begin
          enable = 1'b1;
          drop_active = 0;
        end
      end
      if (tif.trace_strobe) begin
        if (exp_q.size() == 0) check_val("extra_presentation", pres + 1, n_exp);
        else check_val("mem_trace", 32'(tif.mem_trace), 32'(exp_q.pop_front()));
        pres++;
        held = tif.mem_trace;
        waiting = 1;
        done_at = cyc + ((lat > 0) ? lat : int'($urandom_range(1, 4))) - 1;
        if (pres == drop_at) begin
          enable = 1'b0;
          drop_active = 1;
          off_cnt = 0;
        end
        if (pres == abort_at) abort_cyc = cyc;
      end
      if (waiting && cyc == done_at) begin
        tif.access_done = 1'b1;
        tif.access_hit  = (hit_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        if (tif.access_hit) hits++;
        else misses++;
        waiting = 0;
      end else if (spurious && !waiting && !tif.trace_valid && !finished) begin
        tif.access_done = 1'($urandom_range(0, 1));
        tif.access_hit  = 1'b1;
      end
    end
    tif.access_done = 1'b0;

    check_val("finished", {31'd0, finished}, 1);
    check_val("presentations", pres, n_exp);
    check_val("hit_count", 32'(hit_count), sat(hits));
    check_val("miss_count", 32'(miss_count), sat(misses));
    check_val("access_count", 32'(access_count), sat(hits + misses));
    check_val("rom_addr_final", 32'(rom_addr), exp_last);
    check_val("rom_addr_max", max_addr, exp_last);
    check_val("done_valid", {31'd0, tif.trace_valid}, 0);
  endtask

  initial begin
    int fv, ff, n;
    tif.access_done = 1'b0;
    tif.access_hit  = 1'b0;

    fill_rom(2);
    rom[0] = 16'h0010;
    rom[1] = 16'h0020;
    run_trace(3, 0, 0, -1, -1, 0, fv, ff);
    check_val("first_valid_latency", fv, 3);

    fill_rom(0);
    run_trace(3, 0, 0, -1, -1, 0, fv, ff);
    check_val("marker_first_finish", ff, 4);
    check_val("marker_first_no_valid", fv, -1);

    fill_rom(32);
    run_trace(0, 1, 0, -1, -1, 0, fv, ff);

    fill_rom(5);
    run_trace(0, 0, 1, 2, -1, 4, fv, ff);

    fill_rom(2);
    rom[0] = 16'h0040;
    rom[1] = 16'h0040;
    run_trace(2, 0, 0, -1, -1, 0, fv, ff);

    fill_rom(8);
    run_trace(3, 0, 0, -1, 5, 0, fv, ff);
    run_trace(0, 0, 0, -1, -1, 0, fv, ff);

    for (int k = 0; k < 6; k++) begin
      n = $urandom_range(1, 12);
      fill_rom(n);
      run_trace(0, 0, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, n)) : -1,
                -1, $urandom_range(0, 3), fv, ff);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/trace_feeder.md
Name: trace_feeder

Overview:
- Upstream stage of the cache simulator. Replaces the free-running trace source with a handshaked sequencer.
- Reads 16-bit memory addresses from a block-RAM trace ROM (1-cycle read latency) and presents them one at a time to the cache lookup stage.
- Waits for an access-complete pulse carrying hit/miss status, then advances to the next address.
- Keeps the authoritative hit, miss and access counters, and stops at an end marker or at the end of the ROM.

Parameters:
- ADDR_W, 16, width of trace address / mem_trace.
- PTR_W, 10, ROM pointer width.
- TRACE_DEPTH, 1024, number of valid ROM entries (at most 2**PTR_W).
- END_MARKER, 16'hFFFF, ROM word that terminates the trace.
- CNT_W, 16, width of the statistics counters.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- enable  in  1  permits fetching of the next trace entry.
- rom_addr  out  PTR_W  ROM read address.
- rom_data  in  ADDR_W  ROM read data, valid 1 cycle after rom_addr.
- mem_trace  out  ADDR_W  current address presented to the cache.
- trace_valid  out  1  mem_trace is valid and awaiting completion.
- trace_strobe  out  1  one-cycle pulse in the first cycle of each new presentation.
- access_done  in  1  one-cycle pulse from the cache: current access finished.
- access_hit  in  1  qualifies access_done: 1 = hit, 0 = miss.
- hit_count  out  CNT_W  number of hits.
- miss_count  out  CNT_W  number of misses.
- access_count  out  CNT_W  number of completed accesses.
- finished  out  1  trace exhausted; sticky until reset.

Behaviour:
- Reset values: all outputs 0, ptr=0, state IDLE.
- IDLE:
  - enable=1 -> FETCH.
  - enable=0 -> stay in IDLE.
- FETCH:
  - rom_addr=ptr (registered; rom_addr tracks ptr in every state).
  - Next state: CAPTURE.
- CAPTURE:
  - rom_data is valid this cycle.
  - rom_data==END_MARKER -> DONE; no presentation occurs.
  - Otherwise: register rom_data into mem_trace, set trace_valid=1 and trace_strobe=1 at the clock edge, -> PRESENT.
- Latency: trace_valid rises exactly 2 cycles after FETCH is entered.
- PRESENT:
  - trace_valid=1; trace_strobe=1 only in its first cycle.
  - mem_trace is held stable.
  - On access_done=1, at the same edge:
    - access_count+1; hit_count+1 if access_hit, else miss_count+1.
    - trace_valid<=0.
    - If ptr==TRACE_DEPTH-1 -> DONE.
    - Otherwise ptr+1, then -> FETCH if enable, else IDLE.
- DONE: finished=1, trace_valid=0, absorbing until reset. mem_trace keeps its last presented value.
- access_done outside PRESENT is ignored: no counter change, no state change.
- enable deasserted during FETCH, CAPTURE or PRESENT does not abort the in-flight access. It is sampled only at PRESENT exit and in IDLE.
- Counters saturate at all-ones; access_count saturates independently of the others.
- Identical consecutive addresses are each presented with a fresh trace_strobe, so downstream must not rely on a value change.
- Reset asserted mid-operation: immediate return to IDLE; counters, ptr, mem_trace, trace_valid and finished all cleared.
- Invariant: access_count == hit_count + miss_count (absent saturation).

Decomposition:
- Shared package: state encoding (IDLE, FETCH, CAPTURE, PRESENT, DONE), END_MARKER default, CNT_W default.
- One natural sub-module: sat_counter (parameterised width, increment enable, async reset, saturating). Instantiated three times.
- The FSM and pointer stay in trace_feeder.

Test Plan:
- ROM = {0x0010, 0x0020, END_MARKER}, enable=1, consumer sends access_done 3 cycles after each trace_strobe, access_hit=0 then 1 -> mem_trace shows 0x0010 then 0x0020; trace_valid first rises 3 cycles after reset release; final state miss=1, hit=1, access=2, finished=1, rom_addr never exceeds 2.
- ROM[0] = END_MARKER -> finished=1 four cycles after reset release; trace_valid never asserts; all counters 0.
- TRACE_DEPTH=4, no marker, all accesses hits -> exactly 4 presentations; hit_count=4; finished=1; ptr does not wrap to 0.
- Spurious access_done pulses in IDLE, FETCH and CAPTURE -> counters remain 0. enable=0 during PRESENT -> current access completes, then the block parks in IDLE and resumes when enable returns.
- ROM = {0x0040, 0x0040, END_MARKER} -> two separate trace_strobe pulses with unchanged mem_trace; access_count=2.
- Reset asserted 1 cycle into PRESENT of entry 5 (after 4 completed accesses) -> all outputs 0 on the same cycle; after release, the trace restarts from ROM[0].
- CNT_W=4 with 20 hits -> hit_count holds 0xF and access_count holds 0xF.
